// File: rtl/charli_pattern_gen.sv
// Animation source for the 6-LED charlieplexed display: produces the LED frame
// for static, chase, bounce and fill/drain patterns at a programmable step rate.
module charli_pattern_gen #(
  parameter int TICK_DIV = 25000,
  parameter int SPEED_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode_load,
  input  logic [1:0]         mode_in,
  input  logic [SPEED_W-1:0] speed_in,
  input  logic [5:0]         static_in,
  input  logic               pause,
  output logic [5:0]         data,
  output logic               step_tick,
  output logic               cycle_done
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

  localparam logic [1:0] MODE_STATIC = 2'd0;
  localparam logic [1:0] MODE_CHASE  = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_FILL   = 2'd3;

  typedef enum logic [1:0] {ST_OFF, ST_RUN, ST_HOLD} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [1:0]           r_mode;
  logic [SPEED_W-1:0]   r_speed;
  logic [5:0]           r_static;
  logic [PRESC_W-1:0]   r_presc;
  logic [SPEED_W-1:0]   r_stepcnt;
  logic                 r_dir_up;
  logic                 r_drain;
  logic [5:0]           r_data;
  logic                 r_step_tick;
  logic                 r_cycle_done;

  logic [5:0]           w_start;
  logic [5:0]           w_frame_nxt;
  logic                 w_dir_up_nxt;
  logic                 w_drain_nxt;
  logic                 w_cycle_end;
  logic                 w_presc_wrap;
  logic                 w_step;

  assign w_presc_wrap = (r_presc == PRESC_MAX);
  assign w_step       = (r_state == ST_RUN) && w_presc_wrap && (r_stepcnt == r_speed);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_OFF;
    else     r_state <= w_state_nxt;
  end

  // A load always restarts in RUN; pause only acts when no load is present.
  always_comb begin
    w_state_nxt = r_state;
    if (mode_load) begin
      w_state_nxt = ST_RUN;
    end else begin
      case (r_state)
        ST_RUN:  if (pause)  w_state_nxt = ST_HOLD;
        ST_HOLD: if (!pause) w_state_nxt = ST_RUN;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    w_start = 6'b000001;
    if (mode_in == MODE_STATIC)    w_start = static_in;
    else if (mode_in == MODE_FILL) w_start = 6'b000000;
  end

  // Direction / phase flip at the end frames before shifting, so the end frame
  // itself is shown for exactly one step.
  always_comb begin
    w_frame_nxt  = r_data;
    w_dir_up_nxt = r_dir_up;
    w_drain_nxt  = r_drain;
    case (r_mode)
      MODE_STATIC: w_frame_nxt = r_static;
      MODE_CHASE:  w_frame_nxt = {r_data[4:0], r_data[5]};
      MODE_BOUNCE: begin
        if (r_data == 6'b100000)      w_dir_up_nxt = 1'b0;
        else if (r_data == 6'b000001) w_dir_up_nxt = 1'b1;
        w_frame_nxt = w_dir_up_nxt ? {r_data[4:0], 1'b0} : {1'b0, r_data[5:1]};
      end
      MODE_FILL: begin
        if (r_data == 6'b111111)      w_drain_nxt = 1'b1;
        else if (r_data == 6'b000000) w_drain_nxt = 1'b0;
        w_frame_nxt = {r_data[4:0], ~w_drain_nxt};
      end
      default: w_frame_nxt = r_data;
    endcase
  end

  always_comb begin
    w_cycle_end = 1'b0;
    if (r_mode == MODE_CHASE || r_mode == MODE_BOUNCE) w_cycle_end = (w_frame_nxt == 6'b000001);
    else if (r_mode == MODE_FILL)                      w_cycle_end = (w_frame_nxt == 6'b000000);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode       <= '0;
      r_speed      <= '0;
      r_static     <= '0;
      r_presc      <= '0;
      r_stepcnt    <= '0;
      r_dir_up     <= 1'b1;
      r_drain      <= 1'b0;
      r_data       <= '0;
      r_step_tick  <= 1'b0;
      r_cycle_done <= 1'b0;
    end else if (mode_load) begin
      r_mode       <= mode_in;
      r_speed      <= speed_in;
      r_static     <= static_in;
      r_presc      <= '0;
      r_stepcnt    <= '0;
      r_dir_up     <= 1'b1;
      r_drain      <= 1'b0;
      r_data       <= w_start;
      r_step_tick  <= 1'b0;
      r_cycle_done <= 1'b0;
    end else begin
      r_step_tick  <= w_step;
      r_cycle_done <= w_step && w_cycle_end;
      if (r_state == ST_RUN) begin
        if (w_presc_wrap) begin
          r_presc   <= '0;
          r_stepcnt <= (r_stepcnt == r_speed) ? '0 : r_stepcnt + 1'b1;
        end else begin
          r_presc   <= r_presc + 1'b1;
        end
      end
      if (w_step) begin
        r_data   <= w_frame_nxt;
        r_dir_up <= w_dir_up_nxt;
        r_drain  <= w_drain_nxt;
      end
    end
  end

  assign data       = r_data;
  assign step_tick  = r_step_tick;
  assign cycle_done = r_cycle_done;

endmodule

// File: tb/tb_charli_pattern_gen.sv
// Directed bench for charli_pattern_gen with TICK_DIV=4: pattern sequences,
// step timing, pause/hold, load priority and mid-run reset.
module tb_charli_pattern_gen;

  localparam int TICK_DIV = 4;
  localparam int SPEED_W  = 4;

  localparam logic [1:0] M_STATIC = 2'd0;
  localparam logic [1:0] M_CHASE  = 2'd1;
  localparam logic [1:0] M_BOUNCE = 2'd2;
  localparam logic [1:0] M_FILL   = 2'd3;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               mode_load = 1'b0;
  logic [1:0]         mode_in = '0;
  logic [SPEED_W-1:0] speed_in = '0;
  logic [5:0]         static_in = '0;
  logic               pause = 1'b0;
  logic [5:0]         data;
  logic               step_tick;
  logic               cycle_done;

  int n_cmp = 0;
  int n_bad = 0;
  logic [5:0] exp_q[$];

  always #5 clk = ~clk;

  charli_pattern_gen #(.TICK_DIV(TICK_DIV), .SPEED_W(SPEED_W)) dut (
    .clk(clk), .rst(rst), .mode_load(mode_load), .mode_in(mode_in),
    .speed_in(speed_in), .static_in(static_in), .pause(pause),
    .data(data), .step_tick(step_tick), .cycle_done(cycle_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge; returns one falling edge after the strobe,
  // with the mode inputs scrambled so later changes must be ignored.
  task automatic do_load(input logic [1:0] m, input int spd, input logic [5:0] st, input logic pz);
    mode_load = 1'b1;
    mode_in   = m;
    speed_in  = spd[SPEED_W-1:0];
    static_in = st;
    pause     = pz;
    @(negedge clk);
    mode_load = 1'b0;
    pause     = 1'b0;
    mode_in   = ~m;
    speed_in  = '1;
    static_in = ~st;
  endtask

  task automatic wait_tick(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (step_tick !== 1'b1 && n < limit);
  endtask

  task automatic run_steps(input string tag, input int interval, input bit cd_last);
    int n;
    for (int i = 0; i < exp_q.size(); i++) begin
      wait_tick(interval + 4, n);
      check_eq($sformatf("%s step%0d interval", tag, i), n, interval);
      check_eq($sformatf("%s step%0d data", tag, i), data, exp_q[i]);
      check_eq($sformatf("%s step%0d cycle_done", tag, i), cycle_done,
               (cd_last && i == exp_q.size() - 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks;
    int bad_frz;
    int n;

    // Reset, then idle in OFF
    repeat (3) @(negedge clk);
    check_eq("rst data", data, 0);
    rst = 1'b0;
    ticks = 0;
    repeat (200) begin
      @(negedge clk);
      if (step_tick || cycle_done) ticks++;
    end
    check_eq("idle data", data, 0);
    check_eq("idle step_tick", step_tick, 0);
    check_eq("idle cycle_done", cycle_done, 0);
    check_eq("idle pulses", ticks, 0);

    // CHASE speed 0
    do_load(M_CHASE, 0, 6'h00, 1'b0);
    check_eq("chase start", data, 6'h01);
    check_eq("chase load tick", step_tick, 0);
    exp_q = {6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h01};
    run_steps("chase", 4, 1'b1);

    // BOUNCE speed 2
    do_load(M_BOUNCE, 2, 6'h00, 1'b0);
    check_eq("bounce start", data, 6'h01);
    exp_q = {6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h10, 6'h08, 6'h04, 6'h02, 6'h01};
    run_steps("bounce", 12, 1'b1);

    // FILL speed 0
    do_load(M_FILL, 0, 6'h00, 1'b0);
    check_eq("fill start", data, 6'h00);
    exp_q = {6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3F,
             6'h3E, 6'h3C, 6'h38, 6'h30, 6'h20, 6'h00};
    run_steps("fill", 4, 1'b1);

    // STATIC speed 1
    do_load(M_STATIC, 1, 6'h2A, 1'b0);
    check_eq("static start", data, 6'h2A);
    exp_q = {6'h2A, 6'h2A};
    run_steps("static", 8, 1'b0);

    // Pause mid-step on CHASE speed 3
    do_load(M_CHASE, 3, 6'h00, 1'b0);
    check_eq("pause start", data, 6'h01);
    repeat (5) @(negedge clk);
    pause = 1'b1;
    ticks = 0;
    bad_frz = 0;
    repeat (20) begin
      @(negedge clk);
      if (step_tick) ticks++;
      if (data !== 6'h01) bad_frz++;
    end
    pause = 1'b0;
    check_eq("pause ticks", ticks, 0);
    check_eq("pause frozen", bad_frz, 0);
    wait_tick(30, n);
    check_eq("resume interval", n, 11);
    check_eq("resume data", data, 6'h02);

    // Load FILL while held
    pause = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("hold data", data, 6'h02);
    do_load(M_FILL, 0, 6'h00, 1'b1);
    check_eq("load in hold data", data, 6'h00);
    wait_tick(8, n);
    check_eq("load in hold interval", n, 4);
    check_eq("load in hold step", data, 6'h01);

    // Load and pause together from RUN
    do_load(M_CHASE, 0, 6'h00, 1'b1);
    check_eq("load+pause data", data, 6'h01);
    wait_tick(8, n);
    check_eq("load+pause interval", n, 4);
    check_eq("load+pause step", data, 6'h02);

    // Reset mid-BOUNCE while moving down
    do_load(M_BOUNCE, 0, 6'h00, 1'b0);
    exp_q = {6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h10};
    run_steps("bounce2", 4, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst data", data, 0);
    check_eq("midrst step_tick", step_tick, 0);
    check_eq("midrst cycle_done", cycle_done, 0);
    rst = 1'b0;
    ticks = 0;
    repeat (12) begin
      @(negedge clk);
      if (step_tick) ticks++;
    end
    check_eq("off ticks", ticks, 0);
    check_eq("off data", data, 0);
    do_load(M_BOUNCE, 0, 6'h00, 1'b0);
    check_eq("reload start", data, 6'h01);
    exp_q = {6'h02, 6'h04};
    run_steps("reload", 4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
